decode_in_capture_buffer: RTL

Synthesizable capture buffer for the LC-3 decode input bus. It samples `instr_dout`, `enable_decode` and `npc_in` on every rising clock edge and qualifies each sample by a capture mode. Qualified samples are stored in a parametrised FIFO, and a host or debug port drains it through a valid/ready handshake. It sits beside the decode unit as a passive tap: it never drives the decode bus and adds no load to the decode path beyond the tap itself.

---
 rtl/decode_in_capture_pkg.sv | 26 ++
 rtl/decode_in_capture_fifo.sv | 55 +++++
 rtl/decode_in_capture_buffer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/decode_in_capture_pkg.sv
// Shared types and constants for the LC-3 decode-input capture buffer.
// Optional feature macro: DECODE_IN_CAPTURE_TIMESTAMP_EN adds a timestamp to each entry.
package decode_in_capture_pkg;

  localparam int OVF_W       = 16;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_NPC_W   = 16;
  localparam int DEF_TS_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } capture_state_e;

  // Field order matches the packed entry vector built in the top level (MSB first).
  typedef struct packed {
    logic [DEF_INSTR_W-1:0] instr;
    logic [DEF_NPC_W-1:0]   npc;
    logic                   enable;
`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
    logic [DEF_TS_W-1:0]    ts;
`endif
  } capture_entry_t;

endpackage

// File: rtl/decode_in_capture_fifo.sv
// Parametrised FIFO storage for captured decode samples; registered count/full/empty.
// Storage is cleared by reset so the head data reads as zero after reset.
module decode_in_capture_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;
  logic [CW-1:0]    w_countNext;

  assign w_countNext = r_count + CW'(push) - CW'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (push) begin
        r_mem[r_wrPtr] <= wdata;
        r_wrPtr        <= r_wrPtr + AW'(1);
      end
      if (pop) r_rdPtr <= r_rdPtr + AW'(1);
      r_count <= w_countNext;
      r_full  <= (w_countNext == CW'(DEPTH));
      r_empty <= (w_countNext == '0);
    end
  end

  assign rdata = r_mem[r_rdPtr];
  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/decode_in_capture_buffer.sv
// Passive tap on the LC-3 decode input bus: qualifies samples, buffers them, drains via valid/ready.
// Define DECODE_IN_CAPTURE_TIMESTAMP_EN to timestamp entries and expose rd_timestamp.
module decode_in_capture_buffer
  import decode_in_capture_pkg::*;
#(
  parameter int INSTR_W      = 16,
  parameter int NPC_W        = 16,
  parameter int DEPTH        = 8,
  parameter int TS_W         = 16,
  parameter bit STOP_ON_FULL = 1'b0,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr_dout,
  input  logic               enable_decode,
  input  logic [NPC_W-1:0]   npc_in,
  input  logic               start,
  input  logic               stop,
  input  logic               capture_all,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [INSTR_W-1:0] rd_instr,
  output logic [NPC_W-1:0]   rd_npc,
  output logic               rd_enable,
`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
  output logic [TS_W-1:0]    rd_timestamp,
`endif
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic [OVF_W-1:0]   overflow_count,
  output logic [1:0]         state
);

`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
  localparam int TS_BITS = TS_W;
`else
  localparam int TS_BITS = 0;
`endif
  localparam int ENTRY_W = INSTR_W + NPC_W + 1 + TS_BITS;

  capture_state_e     r_state;
  capture_state_e     w_stateNext;
  logic [OVF_W-1:0]   r_overflow;
  logic [ENTRY_W-1:0] w_wdata;
  logic [ENTRY_W-1:0] w_rdata;
  logic [CW-1:0]      w_count;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_qualified;
  logic               w_push;
  logic               w_drop;
  logic               w_freeze;

  assign w_pop       = ~w_empty & rd_ready;
  assign w_qualified = (r_state == RUN) & (capture_all | enable_decode);
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign w_push      = w_qualified & (~w_full | w_pop);
  assign w_drop      = w_qualified & ~w_push;
  assign w_freeze    = STOP_ON_FULL & w_push & ~w_pop & (w_count == CW'(DEPTH - 1));

`ifdef DECODE_IN_CAPTURE_TIMESTAMP_EN
  logic [TS_W-1:0] r_ts;
  logic [TS_W-1:0] w_tsNext;

  // Entries record the value the counter takes at their capture edge.
  assign w_tsNext = start ? '0 : r_ts + TS_W'(1);

  always_ff @(posedge clock) begin
    if (reset) r_ts <= '0;
    else       r_ts <= w_tsNext;
  end

  assign w_wdata      = {instr_dout, npc_in, enable_decode, w_tsNext};
  assign rd_timestamp = w_rdata[TS_BITS-1:0];
`else
  assign w_wdata = {instr_dout, npc_in, enable_decode};
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (!stop && start) w_stateNext = RUN;
      RUN:     if (stop) w_stateNext = IDLE;
               else if (w_freeze) w_stateNext = FROZEN;
      FROZEN:  if (stop) w_stateNext = IDLE;
               else if (start && !w_full) w_stateNext = RUN;
      default: w_stateNext = IDLE;
    endcase
  end

  always_comb begin
    state = r_state;
  end

  always_ff @(posedge clock) begin
    if (reset)                        r_overflow <= '0;
    else if (w_drop && ~&r_overflow)  r_overflow <= r_overflow + OVF_W'(1);
  end

  decode_in_capture_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wdata),
    .rdata (w_rdata),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign rd_instr       = w_rdata[ENTRY_W-1 -: INSTR_W];
  assign rd_npc         = w_rdata[ENTRY_W-INSTR_W-1 -: NPC_W];
  assign rd_enable      = w_rdata[TS_BITS];
  assign rd_valid       = ~w_empty;
  assign count          = w_count;
  assign full           = w_full;
  assign empty          = w_empty;
  assign overflow_count = r_overflow;

endmodule
